microprocessor: RTL and testbench
=================================

# microprocessor

Single-cycle RV32I integer core that retires one instruction per clock. It fetches from an external instruction memory: it drives `pc` and receives the instruction word combinationally on `instruction`. A small word-addressed data memory is held internally. It is the top-level compute block of the processor subsystem; `res_out` exposes each cycle's write-back value for observation.

## Interface
- `DMEM_WORDS`, 256: data memory depth in 32-bit words (power of two).
- `RESET_PC`, 32'h0000_0000: PC value loaded by reset.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `instruction`  input  32  instruction word at address `pc`; must be valid combinationally within the same cycle.
- `pc`  output  32  address of the instruction currently executing (registered).
- `res_out`  output  32  registered value written to `rd` by the last retired instruction; 0 if it wrote nothing.

## Operation
- State: `pc`, 32×32 register file (x0 reads 0, writes to it discarded), data memory, `res_out`.
- Decode from `instruction[6:0]`:
  - OP (0110011): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND. funct7[5] selects SUB/SRA.
  - OP-IMM (0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - LUI (0110111): rd = imm[31:12]<<12.
  - AUIPC (0010111): rd = pc + (imm<<12).
  - JAL (1101111): rd = pc+4; next pc = pc + J-imm.
  - JALR (1100111): rd = pc+4; next pc = (rs1 + I-imm) & ~1.
  - BRANCH (1100011): BEQ, BNE, BLT, BGE, BLTU, BGEU. Taken: pc + B-imm; otherwise pc+4.
  - LOAD (0000011): all funct3 treated as LW. Address = rs1 + I-imm, word index = addr[log2(DMEM_WORDS)+1:2]; addr[1:0] ignored.
  - STORE (0100011): all funct3 treated as SW; same addressing; no rd write.
  - Any other opcode, or an unused funct encoding: NOP (pc+4, no write, `res_out`=0).
- Arithmetic is modulo 2^32. Shift amount is the low 5 bits of the operand. Signed compares are two's complement. Immediates are sign-extended per RV32I formats.
- JAL/JALR with rd=x0: jump still taken; `res_out` = 0, because x0 is not written.
- Register reads occur before the same-cycle write. rs == rd reads the old value.

## Timing
- All architectural state updates on the rising edge of `clk`. Latency from `instruction` sample to register, memory and `res_out` update is 1 cycle.
- Load data is read combinationally from data memory and written to rd at the same edge.
- `rst`=1 at an edge: `pc` ← `RESET_PC`, all registers ← 0, `res_out` ← 0. The data memory is not cleared. The instruction presented that cycle is discarded.
- Reset asserted mid-program takes effect at the next edge, regardless of any branch or store in flight. No store occurs in a reset cycle.
- After `rst` deasserts, the first instruction executes at the first edge with `rst`=0.
- `pc` wraps 0xFFFF_FFFC → 0 on sequential advance. An X or undefined `instruction` while in reset has no effect.

## Test plan
- Reset: hold `rst`=1 for 2 edges with arbitrary `instruction`. Required: `pc`=0, `res_out`=0, x1..x31 = 0.
- ALU sequence: `ADDI x1,x0,5`; `ADDI x2,x0,-3`; `ADD x3,x1,x2`; `SUB x4,x2,x1`; `SRA x5,x2,x1`; `SLTU x6,x1,x2`. Required `res_out` per cycle: 5, 0xFFFFFFFD, 2, 0xFFFFFFF8, 0xFFFFFFFF, 1. `pc` must advance by 4 each cycle.
- Memory: `ADDI x1,x0,0x40`; `SW x1,8(x1)`; `LW x7,8(x1)`. Required: x7 = 0x40, `res_out` = 0x40 on the load, 0 on the store.
- Branches: with x1 = 5, `BEQ x1,x1,+16` at pc 0x10 → next `pc` = 0x20. `BLT x1,x0,+16` → not taken, `pc` = 0x24.
- Jumps and upper immediates: `JAL x1,+8` at pc 0x8 → `res_out` = 0xC, `pc` = 0x10. `JALR x0,0(x1)` → `pc` = 0xC, `res_out` = 0. `LUI x2,0x12345` → 0x12345000. `AUIPC` at pc 0x20 with imm 1 → 0x1020.
- Mid-run reset: assert `rst` during a taken branch. Required: `pc` = 0 and registers cleared next edge. Data memory retains previously stored words. `ADDI x0,x0,7` yields `res_out` = 0 and x0 = 0.

Source files
------------

// File: rtl/microprocessor.sv
// Single-cycle RV32I integer core: external instruction fetch, internal word-addressed
// data memory, one instruction retired per clock, write-back value exposed on res_out.
module microprocessor #(
    parameter int          DMEM_WORDS = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] res_out
);

    localparam int AW = $clog2(DMEM_WORDS);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    logic [31:0] regs [0:31];
    logic [31:0] dmem [0:DMEM_WORDS-1];

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] pc_plus4;
    logic [31:0] mem_addr;
    logic [AW-1:0] mem_idx;
    logic        unused_addr_bits;

    logic        wr_en;
    logic [31:0] wr_data;
    logic        st_en;
    logic [31:0] pc_next;
    logic        take;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct7 = instruction[31:25];

    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u = {instruction[31:12], 12'h000};
    assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

    // x0 is muxed to zero explicitly so it never depends on array contents
    assign rs1_val = (rs1 == 5'd0) ? 32'h0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'h0 : regs[rs2];

    assign pc_plus4 = pc + 32'd4;
    assign mem_addr = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
    assign mem_idx  = mem_addr[AW+1:2];
    assign unused_addr_bits = ^{mem_addr[31:AW+2], mem_addr[1:0]};

    function automatic logic [31:0] alu(input logic [2:0]  f3,
                                        input logic        alt,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            3'b000:  r = alt ? (a - b) : (a + b);
            3'b001:  r = a << b[4:0];
            3'b010:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b011:  r = (a < b) ? 32'd1 : 32'd0;
            3'b100:  r = a ^ b;
            3'b101:  r = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    always_comb begin
        take = 1'b0;
        case (funct3)
            3'b000:  take = (rs1_val == rs2_val);
            3'b001:  take = (rs1_val != rs2_val);
            3'b100:  take = ($signed(rs1_val) < $signed(rs2_val));
            3'b101:  take = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  take = (rs1_val < rs2_val);
            3'b111:  take = (rs1_val >= rs2_val);
            default: take = 1'b0;
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_data = 32'h0;
        st_en   = 1'b0;
        pc_next = pc_plus4;
        case (opcode)
            OPC_OP: begin
                // funct7=0100000 is only defined for SUB and SRA
                if (funct7 == 7'b0000000 ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    wr_en   = 1'b1;
                    wr_data = alu(funct3, funct7[5], rs1_val, rs2_val);
                end
            end
            OPC_OP_IMM: begin
                if (funct3 == 3'b001) begin
                    if (funct7 == 7'b0000000) begin
                        wr_en   = 1'b1;
                        wr_data = alu(funct3, 1'b0, rs1_val, imm_i);
                    end
                end else if (funct3 == 3'b101) begin
                    if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
                        wr_en   = 1'b1;
                        wr_data = alu(funct3, funct7[5], rs1_val, imm_i);
                    end
                end else begin
                    wr_en   = 1'b1;
                    wr_data = alu(funct3, 1'b0, rs1_val, imm_i);
                end
            end
            OPC_LUI: begin
                wr_en   = 1'b1;
                wr_data = imm_u;
            end
            OPC_AUIPC: begin
                wr_en   = 1'b1;
                wr_data = pc + imm_u;
            end
            OPC_JAL: begin
                wr_en   = 1'b1;
                wr_data = pc_plus4;
                pc_next = pc + imm_j;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    wr_en   = 1'b1;
                    wr_data = pc_plus4;
                    pc_next = (rs1_val + imm_i) & ~32'd1;
                end
            end
            OPC_BRANCH: begin
                if (take) pc_next = pc + imm_b;
            end
            OPC_LOAD: begin
                wr_en   = 1'b1;
                wr_data = dmem[mem_idx];
            end
            OPC_STORE: begin
                st_en = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            res_out <= 32'h0;
            for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
        end else begin
            pc <= pc_next;
            if (wr_en && rd != 5'd0) begin
                regs[rd] <= wr_data;
                res_out  <= wr_data;
            end else begin
                res_out  <= 32'h0;
            end
        end
    end

    // Data memory has no reset; it keeps its contents across rst
    always_ff @(posedge clk) begin
        if (!rst && st_en) dmem[mem_idx] <= rs2_val;
    end

endmodule

// File: tb/tb_microprocessor.sv
// Directed bench for the single-cycle RV32I core: each vector gives the instruction,
// the hand-computed res_out and the hand-computed next pc.
module tb_microprocessor;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] res_out;

    int n_tests = 0;
    int n_fail  = 0;

    microprocessor #(.DMEM_WORDS(256), .RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .instruction(instruction),
        .pc         (pc),
        .res_out    (res_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    task automatic exec(input string tag, input logic [31:0] instr,
                        input logic [31:0] exp_res, input logic [31:0] exp_pc);
        instruction = instr;
        @(posedge clk);
        #1;
        check({tag, " res_out"}, res_out, exp_res);
        check({tag, " pc"}, pc, exp_pc);
    endtask

    task automatic reset_cycle(input logic [31:0] instr);
        rst = 1'b1;
        instruction = instr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        instruction = $urandom;

        // power-on reset, two edges with junk instructions
        reset_cycle($urandom);
        reset_cycle($urandom);
        check("reset pc", pc, 32'h0);
        check("reset res_out", res_out, 32'h0);
        rst = 1'b0;

        exec("regs zero a", enc_r(7'b0, 5'd2, 5'd1, 3'b110, 5'd8), 32'h0, 32'h4);
        exec("regs zero b", enc_r(7'b0, 5'd31, 5'd3, 3'b110, 5'd8), 32'h0, 32'h8);

        reset_cycle(32'h0);
        rst = 1'b0;
        exec("addi x1",  enc_i(32'd5, 5'd0, 3'b000, 5'd1, OP_IMM),          32'h0000_0005, 32'h04);
        exec("addi x2",  enc_i(-32'sd3, 5'd0, 3'b000, 5'd2, OP_IMM),        32'hFFFF_FFFD, 32'h08);
        exec("add x3",   enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd3),             32'h0000_0002, 32'h0C);
        exec("sub x4",   enc_r(7'b0100000, 5'd1, 5'd2, 3'b000, 5'd4),       32'hFFFF_FFF8, 32'h10);
        exec("sra x5",   enc_r(7'b0100000, 5'd1, 5'd2, 3'b101, 5'd5),       32'hFFFF_FFFF, 32'h14);
        exec("sltu x6",  enc_r(7'b0, 5'd2, 5'd1, 3'b011, 5'd6),             32'h0000_0001, 32'h18);
        exec("slt x7",   enc_r(7'b0, 5'd1, 5'd2, 3'b010, 5'd7),             32'h0000_0001, 32'h1C);
        exec("srl x8",   enc_r(7'b0, 5'd1, 5'd2, 3'b101, 5'd8),             32'h07FF_FFFF, 32'h20);
        exec("slli x9",  enc_i(32'd3, 5'd1, 3'b001, 5'd9, OP_IMM),          32'h0000_0028, 32'h24);
        exec("xori x10", enc_i(-32'sd1, 5'd1, 3'b100, 5'd10, OP_IMM),       32'hFFFF_FFFA, 32'h28);
        exec("bad funct7", enc_r(7'b0100000, 5'd1, 5'd2, 3'b001, 5'd11),    32'h0, 32'h2C);
        exec("bad opcode", 32'hFFFF_FFFF,                                   32'h0, 32'h30);
        exec("addi x0",  enc_i(32'd7, 5'd0, 3'b000, 5'd0, OP_IMM),          32'h0, 32'h34);
        exec("read x0",  enc_r(7'b0, 5'd0, 5'd0, 3'b110, 5'd11),            32'h0, 32'h38);
        exec("rs==rd",   enc_r(7'b0, 5'd1, 5'd1, 3'b000, 5'd1),             32'h0000_000A, 32'h3C);

        // memory: 0x40 stored at byte 0x48 and 0x40
        exec("addi 0x40", enc_i(32'h40, 5'd0, 3'b000, 5'd1, OP_IMM),        32'h40, 32'h40);
        exec("sw 8(x1)",  enc_s(32'd8, 5'd1, 5'd1),                         32'h0, 32'h44);
        exec("lw x7",     enc_i(32'd8, 5'd1, 3'b010, 5'd7, LOAD),           32'h40, 32'h48);
        exec("mv x12,x7", enc_i(32'd0, 5'd7, 3'b000, 5'd12, OP_IMM),        32'h40, 32'h4C);
        exec("sw 0(x1)",  enc_s(32'd0, 5'd1, 5'd1),                         32'h0, 32'h50);
        exec("addi x2",   enc_i(32'h77, 5'd0, 3'b000, 5'd2, OP_IMM),        32'h77, 32'h54);
        exec("beq pre",   enc_b(32'd16, 5'd1, 5'd1, 3'b000),                32'h0, 32'h64);

        // mid-run reset over a store and a taken branch
        reset_cycle(enc_s(32'd0, 5'd2, 5'd1));
        check("rst store pc", pc, 32'h0);
        reset_cycle(enc_b(32'd16, 5'd1, 5'd1, 3'b000));
        check("rst branch pc", pc, 32'h0);
        check("rst branch res_out", res_out, 32'h0);
        rst = 1'b0;

        exec("x1 cleared", enc_r(7'b0, 5'd0, 5'd1, 3'b000, 5'd13),          32'h0, 32'h04);
        exec("lw 0x48",    enc_i(32'h48, 5'd0, 3'b010, 5'd3, LOAD),         32'h40, 32'h08);
        exec("lw 0x40",    enc_i(32'h40, 5'd0, 3'b010, 5'd4, LOAD),         32'h40, 32'h0C);
        exec("addi x1 5",  enc_i(32'd5, 5'd0, 3'b000, 5'd1, OP_IMM),        32'h5, 32'h10);
        exec("beq taken",  enc_b(32'd16, 5'd1, 5'd1, 3'b000),               32'h0, 32'h20);
        exec("blt nt",     enc_b(32'd16, 5'd0, 5'd1, 3'b100),               32'h0, 32'h24);
        exec("bne back",   enc_b(-32'sd4, 5'd0, 5'd1, 3'b001),              32'h0, 32'h20);
        exec("auipc",      enc_u(20'h00001, 5'd5, AUIPC),                   32'h1020, 32'h24);
        exec("bgeu nt",    enc_b(32'd8, 5'd1, 5'd0, 3'b111),                32'h0, 32'h28);
        exec("bltu back",  enc_b(-32'sd40, 5'd1, 5'd0, 3'b110),             32'h0, 32'h00);
        exec("addi x0 7",  enc_i(32'd7, 5'd0, 3'b000, 5'd0, OP_IMM),        32'h0, 32'h04);
        exec("x0 still 0", enc_r(7'b0, 5'd0, 5'd0, 3'b000, 5'd14),          32'h0, 32'h08);
        exec("jal x1",     enc_j(32'd8, 5'd1),                              32'h0C, 32'h10);
        exec("jalr x0",    enc_i(32'd0, 5'd1, 3'b000, 5'd0, JALR),          32'h0, 32'h0C);
        exec("lui x2",     enc_u(20'h12345, 5'd2, LUI),                     32'h1234_5000, 32'h10);
        exec("jalr lsb",   enc_i(32'd1, 5'd2, 3'b000, 5'd6, JALR),          32'h14, 32'h1234_5000);
        exec("jalr top",   enc_i(-32'sd4, 5'd0, 3'b000, 5'd0, JALR),        32'h0, 32'hFFFF_FFFC);
        exec("pc wrap",    enc_i(32'd1, 5'd0, 3'b000, 5'd7, OP_IMM),        32'h1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
